// File: rtl/osc_pkg.sv
// Shared oscilloscope constants and the wave reader state type.
package osc_pkg;

  localparam int SAMPLE_W = 12;
  localparam int DEPTH    = 256;
  localparam int X_W      = 11;
  localparam int X_START  = 272;
  localparam int Y_ORIGIN = 556;
  localparam int Y_SHIFT  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    COPY    = 2'd2,
    DONE    = 2'd3
  } reader_state_t;

endpackage

// File: rtl/wave_ram.sv
// Snapshot RAM: one synchronous write port, one registered read port.
module wave_ram #(
  parameter int DEPTH    = osc_pkg::DEPTH,
  parameter int SAMPLE_W = osc_pkg::SAMPLE_W,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [SAMPLE_W-1:0] o_rdata
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];

  // Write on request, read every cycle into the output register (no reset so it maps to block RAM).
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/wave_reader.sv
// Consumer side of the trigger capture handshake: copies a finished capture into
// a private snapshot during vertical blanking, and serves per-pixel trace lookups.
//
// Handshake: o_cap_ready high lets the trigger engine capture. The engine raises
// i_cap_done when a capture is complete and holds it while o_cap_ready is low.
// A capture is taken on a rising edge of i_cap_done seen in IDLE; o_cap_ready
// drops on that edge and rises again only after the whole buffer is copied.
// The engine must drop and re-raise i_cap_done to offer the next capture.
module wave_reader #(
  parameter int DEPTH    = osc_pkg::DEPTH,
  parameter int SAMPLE_W = osc_pkg::SAMPLE_W,
  parameter int X_W      = osc_pkg::X_W,
  parameter int X_START  = osc_pkg::X_START,
  parameter int Y_ORIGIN = osc_pkg::Y_ORIGIN,
  parameter int Y_SHIFT  = osc_pkg::Y_SHIFT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_cap_done,
  input  logic [DEPTH-1:0][SAMPLE_W-1:0]     i_samples,
  output logic                               o_cap_ready,
  input  logic                               i_vblank,
  input  logic [X_W-1:0]                     i_pix_x,
  output logic [X_W-1:0]                     o_plot_y,
  output logic                               o_plot_valid,
  output logic                               o_snap_valid,
  output osc_pkg::reader_state_t             o_state
);

  import osc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [X_W-1:0] X_LO  = X_W'(X_START);
  localparam logic [X_W-1:0] X_HI  = X_W'(X_START + DEPTH);
  localparam logic [X_W-1:0] Y_ORG = X_W'(Y_ORIGIN);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

  // The largest scaled sample must not lift the trace above screen row 0.
  if (Y_ORIGIN < (((1 << SAMPLE_W) - 1) >> Y_SHIFT)) begin : g_bad_geometry
    $error("wave_reader: Y_ORIGIN too small for SAMPLE_W/Y_SHIFT, plot_y would underflow");
  end

  reader_state_t       r_state;
  logic                r_cap_prev;
  logic [AW-1:0]       r_idx;
  logic                r_rd_valid;

  logic                w_cap_rise;
  logic                w_we;
  logic [SAMPLE_W-1:0] w_wdata;
  logic                w_in_window;
  logic [AW-1:0]       w_raddr;
  logic [SAMPLE_W-1:0] w_rdata;
  logic [SAMPLE_W-1:0] w_scaled;

  assign w_cap_rise  = i_cap_done & ~r_cap_prev;
  assign w_we        = (r_state == COPY);
  assign w_wdata     = i_samples[r_idx];
  assign w_in_window = (i_pix_x >= X_LO) && (i_pix_x < X_HI);
  assign w_raddr     = AW'(i_pix_x - X_LO);
  assign w_scaled    = w_rdata >> Y_SHIFT;
  assign o_state     = r_state;

  wave_ram #(
    .DEPTH    (DEPTH),
    .SAMPLE_W (SAMPLE_W),
    .AW       (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Previous cap_done for edge detection; tracks the input every cycle in every state.
  always_ff @(posedge clk) begin
    if (rst) r_cap_prev <= 1'b0;
    else     r_cap_prev <= i_cap_done;
  end

  // Capture FSM: wait for a new capture, wait for blanking, copy all samples, release the engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      o_cap_ready  <= 1'b1;
      o_snap_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cap_rise) begin
            r_state     <= WAIT_VB;
            o_cap_ready <= 1'b0;
          end
        end
        WAIT_VB: begin
          if (i_vblank) begin
            r_state <= COPY;
            r_idx   <= '0;
          end
        end
        COPY: begin
          // Runs to completion even if blanking ends mid-copy.
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) r_state <= DONE;
        end
        DONE: begin
          o_cap_ready  <= 1'b1;
          o_snap_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lookup pipeline: stage 1 is the RAM read register, stage 2 maps the sample to a screen row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid   <= 1'b0;
      o_plot_valid <= 1'b0;
      o_plot_y     <= '0;
    end else begin
      r_rd_valid   <= w_in_window && o_snap_valid && (r_state != COPY);
      o_plot_valid <= r_rd_valid;
      if (r_rd_valid) o_plot_y <= Y_ORG - X_W'(w_scaled);
    end
  end

endmodule
